// File: rtl/im_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM state encodings and
// the byte-lane layout of a 32-bit little-endian word.
package im_loader_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam int         BYTE_W    = 8;
  localparam logic [1:0] LAST_LANE = 2'd3;

endpackage

// File: rtl/im_loader_word_assembler.sv
// Packs payload bytes into little-endian words and keeps the running XOR
// checksum; flags the cycle on which the fourth byte of a word arrives.
module word_assembler
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic        o_word_ready,
  output logic [31:0] o_word,
  output logic [7:0]  o_checksum
);

  logic [1:0]  r_idx;
  logic [31:0] r_lanes;
  logic [7:0]  r_chk;
  logic [31:0] w_merged;

  // The completed word includes the byte arriving this cycle so the writer
  // can register it on the same edge.
  always_comb begin
    w_merged = r_lanes;
    w_merged[{r_idx, 3'b000} +: BYTE_W] = i_byte;
  end

  assign o_word_ready = i_byte_en && (r_idx == LAST_LANE);
  assign o_word       = w_merged;
  assign o_checksum   = r_chk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_lanes <= '0;
      r_chk   <= '0;
    end else if (i_clear) begin
      r_idx   <= '0;
      r_lanes <= '0;
      r_chk   <= '0;
    end else if (i_byte_en) begin
      r_lanes <= w_merged;
      r_idx   <= r_idx + 2'd1;
      r_chk   <= r_chk ^ i_byte;
    end
  end

endmodule

// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: turns a length/payload/checksum byte
// frame into word writes and releases the CPU reset once the image verifies.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int MAX_WORDS = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error
);

  logic [2:0]        r_state;
  logic [15:0]       r_len;
  logic [15:0]       r_word_idx;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic              r_cpu_rst_n;
  logic              r_done;
  logic              r_error;

  logic              w_data_byte;
  logic              w_word_ready;
  logic [31:0]       w_word;
  logic [7:0]        w_checksum;
  logic [15:0]       w_len_full;

  // A load request wins over a byte on the same cycle, so that byte never
  // reaches the assembler.
  assign w_data_byte = byte_valid && !load_req && (r_state == S_DATA);
  assign w_len_full  = {byte_data, r_len[7:0]};

  word_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (load_req),
    .i_byte_en    (w_data_byte),
    .i_byte       (byte_data),
    .o_word_ready (w_word_ready),
    .o_word       (w_word),
    .o_checksum   (w_checksum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_word_idx  <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_cpu_rst_n <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (load_req) begin
        r_state     <= S_LEN_LO;
        r_word_idx  <= '0;
        r_cpu_rst_n <= 1'b0;
        r_done      <= 1'b0;
        r_error     <= 1'b0;
      end else begin
        case (r_state)
          S_LEN_LO: begin
            if (byte_valid) begin
              r_len[7:0] <= byte_data;
              r_state    <= S_LEN_HI;
            end
          end
          S_LEN_HI: begin
            if (byte_valid) begin
              r_len[15:8] <= byte_data;
              if (w_len_full > 16'(MAX_WORDS)) begin
                r_state <= S_ERR;
                r_error <= 1'b1;
              end else if (w_len_full == 16'd0) begin
                r_state <= S_CHECK;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
          // The last word moves straight to CHECK so a checksum byte arriving
          // while that write is on the bus is still caught.
          S_DATA: begin
            if (w_word_ready) begin
              r_we       <= 1'b1;
              r_waddr    <= ADDR_W'({r_word_idx, 2'b00});
              r_wdata    <= w_word;
              r_word_idx <= r_word_idx + 16'd1;
              if ((r_word_idx + 16'd1) == r_len) begin
                r_state <= S_CHECK;
              end
            end
          end
          S_CHECK: begin
            if (byte_valid) begin
              if (byte_data == w_checksum) begin
                r_state     <= S_DONE;
                r_done      <= 1'b1;
                r_cpu_rst_n <= 1'b1;
              end else begin
                r_state <= S_ERR;
                r_error <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign we        = r_we;
  assign waddr     = r_waddr;
  assign wdata     = r_wdata;
  assign cpu_rst_n = r_cpu_rst_n;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: a frame-position model predicts every
// output each cycle, and directed frames pin the model with literal values.
module tb_im_loader;

  localparam int ADDR_W    = 16;
  localparam int MAX_WORDS = 128;

  logic              clk        = 1'b0;
  logic              rst_n      = 1'b0;
  logic              load_req   = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data  = 8'h00;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              cpu_rst_n;
  logic              done;
  logic              error;

  int checks   = 0;
  int failures = 0;

  im_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_req   (load_req),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .cpu_rst_n  (cpu_rst_n),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: every accepted byte is classified purely by its position
  // in the frame since the last load request (length, payload, checksum, tail).
  logic        m_active = 1'b0;
  int          m_pos    = 0;
  int          m_len    = 0;
  logic        m_done   = 1'b0;
  logic        m_err    = 1'b0;
  logic        m_we     = 1'b0;
  logic [15:0] m_waddr  = 16'h0;
  logic [31:0] m_wdata  = 32'h0;
  logic [7:0]  m_pay [0:4*MAX_WORDS-1];
  int          m_k;
  logic [7:0]  m_x;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_pos    = 0;
      m_len    = 0;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_we     = 1'b0;
      m_waddr  = 16'h0;
      m_wdata  = 32'h0;
    end else begin
      m_we = 1'b0;
      if (load_req) begin
        m_active = 1'b1;
        m_pos    = 0;
        m_done   = 1'b0;
        m_err    = 1'b0;
      end else if (byte_valid && m_active && !m_done && !m_err) begin
        if (m_pos == 0) begin
          m_len = int'(byte_data);
        end else if (m_pos == 1) begin
          m_len = m_len + 256 * int'(byte_data);
          if (m_len > MAX_WORDS) m_err = 1'b1;
        end else if (m_pos < 2 + 4 * m_len) begin
          m_k        = m_pos - 2;
          m_pay[m_k] = byte_data;
          if (m_k % 4 == 3) begin
            m_we    = 1'b1;
            m_waddr = 16'((m_k / 4) * 4);
            m_wdata = {m_pay[m_k], m_pay[m_k-1], m_pay[m_k-2], m_pay[m_k-3]};
          end
        end else begin
          m_x = 8'h00;
          for (int i = 0; i < 4 * m_len; i++) m_x = m_x ^ m_pay[i];
          if (m_x == byte_data) m_done = 1'b1;
          else                  m_err  = 1'b1;
        end
        m_pos++;
      end
    end
  end

  logic [15:0] wr_addr [$];
  logic [31:0] wr_data [$];

  always @(negedge clk) begin
    checkOutput("cyc_we",        32'(we),        32'(m_we));
    checkOutput("cyc_waddr",     32'(waddr),     32'(m_waddr));
    checkOutput("cyc_wdata",     wdata,          m_wdata);
    checkOutput("cyc_done",      32'(done),      32'(m_done));
    checkOutput("cyc_error",     32'(error),     32'(m_err));
    checkOutput("cyc_cpu_rst_n", 32'(cpu_rst_n), 32'(m_done));
    if (we) begin
      wr_addr.push_back(waddr);
      wr_data.push_back(wdata);
    end
  end

  // One clock of stimulus; always entered and left 1 time unit after a rising edge.
  task automatic applyStimulus(input logic l, input logic v, input logic [7:0] d);
    load_req   = l;
    byte_valid = v;
    byte_data  = d;
    @(posedge clk);
    #1;
    load_req   = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  logic [7:0] frm [$];

  task automatic sendFrame(input int gap);
    for (int i = 0; i < frm.size(); i++) begin
      applyStimulus(1'b0, 1'b1, frm[i]);
      idleCycles(gap);
    end
  endtask

  task automatic startLoad();
    wr_addr.delete();
    wr_data.delete();
    applyStimulus(1'b1, 1'b0, 8'h00);
  endtask

  task automatic checkStatus(input string tag, input logic d, input logic e, input logic c);
    checkOutput({tag, "_done"},      32'(done),      32'(d));
    checkOutput({tag, "_error"},     32'(error),     32'(e));
    checkOutput({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(c));
  endtask

  // Payload 13 05 00 00 93 02 40 04 XORs to 0xC3.
  task automatic checkTwoWordImage(input string tag);
    checkOutput({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() >= 2) begin
      checkOutput({tag, "_a0"}, 32'(wr_addr[0]), 32'h0);
      checkOutput({tag, "_d0"}, wr_data[0],      32'h00000513);
      checkOutput({tag, "_a1"}, 32'(wr_addr[1]), 32'h4);
      checkOutput({tag, "_d1"}, wr_data[1],      32'h04400293);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_we"},    32'(we),    32'h0);
    checkOutput({tag, "_waddr"}, 32'(waddr), 32'h0);
    checkOutput({tag, "_wdata"}, wdata,      32'h0);
    checkStatus(tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n, gap, abort_at, sel;
    logic [7:0] x;

    #1;
    checkResetOutputs("rst");
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(1'b0, 1'b1, 8'h5A);
    idleCycles(1);
    checkStatus("idle_ignore", 1'b0, 1'b0, 1'b0);

    startLoad();
    frm = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h02, 8'h40, 8'h04, 8'hC3};
    sendFrame(0);
    idleCycles(3);
    checkTwoWordImage("good");
    checkStatus("good", 1'b1, 1'b0, 1'b1);

    startLoad();
    frm = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h02, 8'h40, 8'h04, 8'h00};
    sendFrame(0);
    idleCycles(3);
    checkTwoWordImage("badchk");
    checkStatus("badchk", 1'b0, 1'b1, 1'b0);

    startLoad();
    frm = '{8'h81, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    sendFrame(0);
    idleCycles(3);
    checkOutput("toolong_nwr", 32'(wr_addr.size()), 32'd0);
    checkStatus("toolong", 1'b0, 1'b1, 1'b0);

    startLoad();
    frm = '{8'h00, 8'h00, 8'h00};
    sendFrame(0);
    idleCycles(2);
    checkOutput("n0ok_nwr", 32'(wr_addr.size()), 32'd0);
    checkStatus("n0ok", 1'b1, 1'b0, 1'b1);

    startLoad();
    frm = '{8'h00, 8'h00, 8'h01};
    sendFrame(0);
    idleCycles(2);
    checkOutput("n0bad_nwr", 32'(wr_addr.size()), 32'd0);
    checkStatus("n0bad", 1'b0, 1'b1, 1'b0);

    startLoad();
    frm = '{8'h01, 8'h00, 8'h73, 8'h00};
    sendFrame(0);
    wr_addr.delete();
    wr_data.delete();
    applyStimulus(1'b1, 1'b1, 8'h55);
    frm = '{8'h01, 8'h00, 8'h73, 8'h00, 8'h00, 8'h00, 8'h73};
    sendFrame(0);
    idleCycles(3);
    checkOutput("abort_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() >= 1) begin
      checkOutput("abort_a0", 32'(wr_addr[0]), 32'h0);
      checkOutput("abort_d0", wr_data[0],      32'h00000073);
    end
    checkStatus("abort", 1'b1, 1'b0, 1'b1);

    startLoad();
    frm = '{8'h02, 8'h00, 8'h13, 8'h05};
    sendFrame(0);
    #2 rst_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b1, 8'hAA);
    startLoad();
    frm = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h02, 8'h40, 8'h04, 8'hC3};
    sendFrame(1);
    idleCycles(3);
    checkTwoWordImage("gap");
    checkStatus("gap", 1'b1, 1'b0, 1'b1);

    for (int f = 0; f < 30; f++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      n = 129 + int'($urandom_range(0, 300));
      else if (sel == 1) n = 0;
      else               n = int'($urandom_range(1, 6));
      if (f == 12) n = MAX_WORDS;
      gap = int'($urandom_range(0, 2));
      frm.delete();
      frm.push_back(8'(n));
      frm.push_back(8'(n >> 8));
      x = 8'h00;
      if (n <= MAX_WORDS) begin
        for (int i = 0; i < 4 * n; i++) begin
          frm.push_back(8'($urandom));
          x = x ^ frm[frm.size()-1];
        end
        frm.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : x);
      end
      for (int i = 0; i < 3; i++) frm.push_back(8'($urandom));
      abort_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, frm.size() - 1)) : -1;
      applyStimulus(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < frm.size(); i++) begin
        if (i == abort_at) begin
          applyStimulus(1'b1, 1'b1, frm[i]);
          break;
        end
        applyStimulus(1'b0, 1'b1, frm[i]);
        idleCycles(gap);
      end
      idleCycles(2);
    end

    idleCycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
